// File: rtl/tristate_bus_xcvr.sv
// -----------------------------------------------------------------------------
// tristate_bus_xcvr
//
// Half-duplex transceiver for a shared tri-state bus. A local transmit request
// is accepted only while the bus is idle. The word is latched and the block
// waits a guard interval of TURN cycles. It then drives the word with a
// one-cycle strobe and waits a release interval of TURN cycles before it goes
// back to idle. A peer strobe seen while idle or guarding captures the bus
// into rx_data. A peer strobe seen while driving sets the sticky collision
// flag.
//
// Ports
//   clk        rising-edge clock for all state
//   reset_n    asynchronous active-low reset
//   tx_req     local request to transmit tx_data
//   tx_data    word to transmit, sampled on acceptance
//   tx_ack     one-cycle pulse, request accepted
//   bus_io     shared tri-state bus
//   bus_stb_o  local data-valid strobe, high only while driving
//   bus_stb_i  peer data-valid strobe
//   rx_data    last word captured from the bus
//   rx_valid   one-cycle pulse, rx_data updated
//   oe         local driver enable (observation)
//   busy       high in any state other than IDLE
//   collision  sticky, peer strobe seen while driving
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus released, accepts tx_req or captures peer data
// GUARD   | word latched, turnaround countdown before driving
// DRIVE   | bus driven with strobe for exactly one cycle
// RELEASE | bus released, turnaround countdown before idle
// -----------------------------------------------------------------------------
module tristate_bus_xcvr #(
    parameter int WIDTH = 8,
    parameter int TURN  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tx_req,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ack,
    inout  wire  [WIDTH-1:0] bus_io,
    output logic             bus_stb_o,
    input  logic             bus_stb_i,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             oe,
    output logic             busy,
    output logic             collision
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GUARD   = 2'd1;
    localparam logic [1:0] S_DRIVE   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [3:0] TURN_CNT = 4'(TURN);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_word_q, tx_word_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             tx_ack_q, tx_ack_d;
    logic             rx_valid_q, rx_valid_d;
    logic             collision_q, collision_d;
    logic             drive_q, drive_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_word_d   = tx_word_q;
        rx_data_d   = rx_data_q;
        tx_ack_d    = 1'b0;
        rx_valid_d  = 1'b0;
        collision_d = collision_q;

        case (state_q)
            S_IDLE: begin
                // A peer transfer wins over a local request in the same cycle.
                if (bus_stb_i) begin
                    rx_data_d  = bus_io;
                    rx_valid_d = 1'b1;
                end else if (tx_req) begin
                    tx_word_d = tx_data;
                    tx_ack_d  = 1'b1;
                    cnt_d     = TURN_CNT;
                    state_d   = S_GUARD;
                end
            end
            S_GUARD: begin
                // Peer activity restarts the full guard interval. The latched
                // word is kept.
                if (bus_stb_i) begin
                    rx_data_d  = bus_io;
                    rx_valid_d = 1'b1;
                    cnt_d      = TURN_CNT;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DRIVE: begin
                if (bus_stb_i) begin
                    collision_d = 1'b1;
                end
                cnt_d   = TURN_CNT;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase

        // The output flags are decoded from the next state, so they change in
        // the same clock as the state register.
        drive_d = (state_d == S_DRIVE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            tx_word_q   <= '0;
            rx_data_q   <= '0;
            tx_ack_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            collision_q <= 1'b0;
            drive_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_word_q   <= tx_word_d;
            rx_data_q   <= rx_data_d;
            tx_ack_q    <= tx_ack_d;
            rx_valid_q  <= rx_valid_d;
            collision_q <= collision_d;
            drive_q     <= drive_d;
            busy_q      <= busy_d;
        end
    end

    // This is the only driver of the bus. Reset clears drive_q asynchronously,
    // so the bus is released without waiting for a clock edge.
    assign bus_io    = drive_q ? tx_word_q : {WIDTH{1'bz}};

    assign tx_ack    = tx_ack_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign oe        = drive_q;
    assign bus_stb_o = drive_q;
    assign busy      = busy_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_tristate_bus_xcvr.sv
module tb_tristate_bus_xcvr;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_vec;
    int   n_err;

    // DUT with TURN=1
    logic       req1, stbi1, pen1;
    logic [7:0] dat1, peer1, rxd1;
    logic       ack1, stbo1, rxv1, oe1, busy1, col1;
    wire  [7:0] bus1;
    assign bus1 = pen1 ? peer1 : 8'hzz;

    // DUT with TURN=3
    logic       req3, stbi3, pen3;
    logic [7:0] dat3, peer3, rxd3;
    logic       ack3, stbo3, rxv3, oe3, busy3, col3;
    wire  [7:0] bus3;
    assign bus3 = pen3 ? peer3 : 8'hzz;

    ev_t ack1_q[$], drv1_q[$], rx1_q[$];
    ev_t ack3_q[$], drv3_q[$], rx3_q[$];

    tristate_bus_xcvr #(.WIDTH(8), .TURN(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .tx_req(req1), .tx_data(dat1),
        .tx_ack(ack1), .bus_io(bus1), .bus_stb_o(stbo1), .bus_stb_i(stbi1),
        .rx_data(rxd1), .rx_valid(rxv1), .oe(oe1), .busy(busy1),
        .collision(col1)
    );

    tristate_bus_xcvr #(.WIDTH(8), .TURN(3)) u_d3 (
        .clk(clk), .reset_n(reset_n), .tx_req(req3), .tx_data(dat3),
        .tx_ack(ack3), .bus_io(bus3), .bus_stb_o(stbo3), .bus_stb_i(stbi3),
        .rx_data(rxd3), .rx_valid(rxv3), .oe(oe3), .busy(busy3),
        .collision(col3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sb(input string nm, input int sz, input ev_t e,
                      input logic [7:0] act_d, input logic chk_d);
        check({nm, "_expected"}, 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            check({nm, "_cycle"}, cyc, e.cyc);
            if (chk_d) check({nm, "_data"}, {24'd0, act_d}, {24'd0, e.d});
        end
    endtask

    // Monitors: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        ev_t e;
        int  sz;
        #1;
        if (ack1) begin
            sz = ack1_q.size(); e = '{0, 8'h00};
            if (sz != 0) e = ack1_q.pop_front();
            sb("d1_ack", sz, e, 8'h00, 1'b0);
        end
        if (stbo1) begin
            sz = drv1_q.size(); e = '{0, 8'h00};
            if (sz != 0) e = drv1_q.pop_front();
            sb("d1_drive", sz, e, bus1, 1'b1);
            check("d1_drive_oe", {31'd0, oe1}, 32'd1);
        end
        if (rxv1) begin
            sz = rx1_q.size(); e = '{0, 8'h00};
            if (sz != 0) e = rx1_q.pop_front();
            sb("d1_rx", sz, e, rxd1, 1'b1);
        end
        if (ack3) begin
            sz = ack3_q.size(); e = '{0, 8'h00};
            if (sz != 0) e = ack3_q.pop_front();
            sb("d3_ack", sz, e, 8'h00, 1'b0);
        end
        if (stbo3) begin
            sz = drv3_q.size(); e = '{0, 8'h00};
            if (sz != 0) e = drv3_q.pop_front();
            sb("d3_drive", sz, e, bus3, 1'b1);
            check("d3_drive_oe", {31'd0, oe3}, 32'd1);
        end
        if (rxv3) begin
            sz = rx3_q.size(); e = '{0, 8'h00};
            if (sz != 0) e = rx3_q.pop_front();
            sb("d3_rx", sz, e, rxd3, 1'b1);
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_d1_ack"},  {31'd0, ack1},  32'd0);
        check({tag, "_d1_rxv"},  {31'd0, rxv1},  32'd0);
        check({tag, "_d1_busy"}, {31'd0, busy1}, 32'd0);
        check({tag, "_d1_col"},  {31'd0, col1},  32'd0);
        check({tag, "_d1_oe"},   {31'd0, oe1},   32'd0);
        check({tag, "_d1_stbo"}, {31'd0, stbo1}, 32'd0);
        check({tag, "_d1_rxd"},  {24'd0, rxd1},  32'd0);
        check({tag, "_d3_ack"},  {31'd0, ack3},  32'd0);
        check({tag, "_d3_busy"}, {31'd0, busy3}, 32'd0);
        check({tag, "_d3_col"},  {31'd0, col3},  32'd0);
        check({tag, "_d3_oe"},   {31'd0, oe3},   32'd0);
        check({tag, "_d3_rxd"},  {24'd0, rxd3},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        clk = 0; cyc = 0; n_vec = 0; n_err = 0;
        reset_n = 1;
        req1 = 0; stbi1 = 0; pen1 = 0; dat1 = 0; peer1 = 0;
        req3 = 0; stbi3 = 0; pen3 = 0; dat3 = 0; peer3 = 0;
        #2 reset_n = 0;
        #1 reset_checks("rst");
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);

        // Single transmit, TURN=1: ack at +1, drive at +2, idle at +4.
        n = cyc; req1 = 1; dat1 = 8'hA5;
        ack1_q.push_back('{n + 1, 8'h00});
        drv1_q.push_back('{n + 2, 8'hA5});
        @(negedge clk); req1 = 0; dat1 = 8'h00;
        @(negedge clk);
        @(negedge clk); check("txA_busy_release", {31'd0, busy1}, 32'd1);
        check("txA_oe_release", {31'd0, oe1}, 32'd0);
        @(negedge clk); check("txA_busy_idle", {31'd0, busy1}, 32'd0);
        repeat (2) @(negedge clk);

        // Peer word in IDLE.
        n = cyc; stbi1 = 1; pen1 = 1; peer1 = 8'h3C;
        rx1_q.push_back('{n + 1, 8'h3C});
        @(negedge clk); stbi1 = 0; pen1 = 0;
        check("rxB_oe", {31'd0, oe1}, 32'd0);
        check("rxB_busy", {31'd0, busy1}, 32'd0);
        repeat (3) @(negedge clk);

        // tx_req and peer strobe in the same cycle: receive wins, then ack.
        n = cyc; req1 = 1; dat1 = 8'hC3; stbi1 = 1; pen1 = 1; peer1 = 8'h5A;
        rx1_q.push_back('{n + 1, 8'h5A});
        ack1_q.push_back('{n + 2, 8'h00});
        drv1_q.push_back('{n + 3, 8'hC3});
        @(negedge clk); stbi1 = 0; pen1 = 0;
        @(negedge clk); req1 = 0;
        repeat (5) @(negedge clk);

        // tx_req held high: one ack per transfer, re-accepted on return to IDLE.
        n = cyc; req1 = 1; dat1 = 8'h11;
        ack1_q.push_back('{n + 1, 8'h00});
        drv1_q.push_back('{n + 2, 8'h11});
        ack1_q.push_back('{n + 5, 8'h00});
        drv1_q.push_back('{n + 6, 8'h22});
        @(negedge clk); dat1 = 8'h22;
        repeat (4) @(negedge clk); req1 = 0;
        repeat (6) @(negedge clk);

        // TURN=3 transmit without deferral: drive at +4.
        n = cyc; req3 = 1; dat3 = 8'h77;
        ack3_q.push_back('{n + 1, 8'h00});
        drv3_q.push_back('{n + 4, 8'h77});
        @(negedge clk); req3 = 0;
        repeat (10) @(negedge clk);

        // TURN=3 peer strobe during GUARD: the guard interval restarts and
        // the original word is still the one driven.
        n = cyc; req3 = 1; dat3 = 8'hE7;
        ack3_q.push_back('{n + 1, 8'h00});
        @(negedge clk); req3 = 0; dat3 = 8'h00;
        @(negedge clk); stbi3 = 1; pen3 = 1; peer3 = 8'h4B;
        rx3_q.push_back('{n + 3, 8'h4B});
        drv3_q.push_back('{n + 6, 8'hE7});
        @(negedge clk); stbi3 = 0; pen3 = 0;
        check("guardE_busy", {31'd0, busy3}, 32'd1);
        check("guardE_oe", {31'd0, oe3}, 32'd0);
        repeat (10) @(negedge clk);

        // Peer strobe during DRIVE and RELEASE: the collision flag is sticky,
        // there is no capture, and the transfer completes.
        n = cyc; req1 = 1; dat1 = 8'h69;
        ack1_q.push_back('{n + 1, 8'h00});
        drv1_q.push_back('{n + 2, 8'h69});
        @(negedge clk); req1 = 0;
        check("colF_before", {31'd0, col1}, 32'd0);
        @(negedge clk); stbi1 = 1;
        @(negedge clk); check("colF_set", {31'd0, col1}, 32'd1);
        @(negedge clk); stbi1 = 0;
        repeat (5) @(negedge clk);
        check("colF_sticky", {31'd0, col1}, 32'd1);
        check("colF_other_dut", {31'd0, col3}, 32'd0);
        check("colF_rxd_kept", {24'd0, rxd1}, 32'h5A);

        // Reset mid-DRIVE releases the bus without waiting for a clock edge.
        n = cyc; req1 = 1; dat1 = 8'hF0;
        ack1_q.push_back('{n + 1, 8'h00});
        drv1_q.push_back('{n + 2, 8'hF0});
        @(negedge clk); req1 = 0;
        @(negedge clk);
        check("rstG_oe_drive", {31'd0, oe1}, 32'd1);
        check("rstG_bus_drive", {24'd0, bus1}, 32'hF0);
        #2 reset_n = 0;
        #1 reset_checks("rstG");
        peer1 = 8'h96; pen1 = 1;
        #1 check("rstG_bus_released", {24'd0, bus1}, 32'h96);
        @(negedge clk); reset_n = 1; pen1 = 0;
        repeat (6) @(negedge clk);
        check("rstG_no_replay_busy", {31'd0, busy1}, 32'd0);

        check("end_d1_ack_left", ack1_q.size(), 32'd0);
        check("end_d1_drv_left", drv1_q.size(), 32'd0);
        check("end_d1_rx_left",  rx1_q.size(),  32'd0);
        check("end_d3_ack_left", ack3_q.size(), 32'd0);
        check("end_d3_drv_left", drv3_q.size(), 32'd0);
        check("end_d3_rx_left",  rx3_q.size(),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
